// File: rtl/gpu_pkg.sv
// Shared GPU definitions: field widths, opcodes and the packed instruction
// record that travels from the instruction FIFO head into the dispatcher.
package gpu_pkg;

  localparam int WIDTH_BITS   = 10;
  localparam int HEIGHT_BITS  = 9;
  localparam int CHANNEL_BITS = 8;

  typedef enum logic [3:0] {
    OP_NOP    = 4'd0,
    OP_LINE   = 4'd1,
    OP_CIRCLE = 4'd2,
    OP_RECT   = 4'd3,
    OP_CLEAR  = 4'd4
  } gpu_opcode_t;

  // 79-bit instruction. The opcode sits in the LSBs. It is kept as raw bits
  // rather than the enum so that undefined opcodes survive latching.
  typedef struct packed {
    logic [2:0]              oct;
    logic [CHANNEL_BITS-1:0] b;
    logic [CHANNEL_BITS-1:0] g;
    logic [CHANNEL_BITS-1:0] r;
    logic [HEIGHT_BITS-1:0]  y2;
    logic [HEIGHT_BITS-1:0]  y1;
    logic [WIDTH_BITS-1:0]   rad;
    logic [WIDTH_BITS-1:0]   x2;
    logic [WIDTH_BITS-1:0]   x1;
    logic [3:0]              opcode;
  } gpu_instr_t;

endpackage

// File: rtl/gpu_dispatch_timer.sv
// WAIT-state watchdog for the instruction dispatcher.
// The module exists only when GPU_DISPATCH_TIMEOUT_EN is defined, so the
// default build carries no unused module.
// load clears the count. enable advances it. expire flags the last allowed
// cycle (count == TIMEOUT_CYCLES-1) while enabled.
`ifdef GPU_DISPATCH_TIMEOUT_EN
module gpu_dispatch_timer #(
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic clk,
  input  logic n_rst,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] count_reg;

  // Cycle counter: restarts on load and advances while the dispatcher waits.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expire = enable && (count_reg == CW'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/gpu_instruction_dispatch.sv
// GPU instruction dispatcher. It pops the FIFO head, latches the operands,
// decodes the opcode, starts the line/circle/fill engine and waits for that
// engine's done.
// Optional build macro GPU_DISPATCH_TIMEOUT_EN adds a WAIT watchdog. When it
// fires, timeout_o is set (sticky) and the instruction is dropped.
module gpu_instruction_dispatch
  import gpu_pkg::*;
#(
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    fifo_empty_i,
  input  logic [3:0]              opcode_i,
  input  logic [WIDTH_BITS-1:0]   x1_i,
  input  logic [WIDTH_BITS-1:0]   x2_i,
  input  logic [WIDTH_BITS-1:0]   rad_i,
  input  logic [HEIGHT_BITS-1:0]  y1_i,
  input  logic [HEIGHT_BITS-1:0]  y2_i,
  input  logic [CHANNEL_BITS-1:0] r_i,
  input  logic [CHANNEL_BITS-1:0] g_i,
  input  logic [CHANNEL_BITS-1:0] b_i,
  input  logic [2:0]              oct_i,
  output logic                    pop_instruction_o,
  output logic                    line_start_o,
  output logic                    circle_start_o,
  output logic                    fill_start_o,
  input  logic                    line_done_i,
  input  logic                    circle_done_i,
  input  logic                    fill_done_i,
  output logic [WIDTH_BITS-1:0]   x1_o,
  output logic [WIDTH_BITS-1:0]   x2_o,
  output logic [WIDTH_BITS-1:0]   rad_o,
  output logic [HEIGHT_BITS-1:0]  y1_o,
  output logic [HEIGHT_BITS-1:0]  y2_o,
  output logic [CHANNEL_BITS-1:0] r_o,
  output logic [CHANNEL_BITS-1:0] g_o,
  output logic [CHANNEL_BITS-1:0] b_o,
  output logic [2:0]              oct_o,
  output logic                    busy_o,
  output logic                    illegal_op_o,
  output logic                    timeout_o,
  output logic [15:0]             instr_count_o
);

  typedef enum logic [1:0] {IDLE, DECODE, WAIT} state_t;

  state_t     state_reg, state_next;
  gpu_instr_t instr_reg, head;
  logic [15:0] count_reg;
  logic       timeout_reg;
  logic       pop, count_inc, timeout_set, sel_done, timer_expire;

  // Assemble the FIFO head. CLEAR is rewritten to a full-screen fill here,
  // so the latched operands are already correct from DECODE onward.
  always_comb begin
    head.opcode = opcode_i;
    head.x1     = x1_i;
    head.x2     = x2_i;
    head.rad    = rad_i;
    head.y1     = y1_i;
    head.y2     = y2_i;
    head.r      = r_i;
    head.g      = g_i;
    head.b      = b_i;
    head.oct    = oct_i;
    if (opcode_i == OP_CLEAR) begin
      head.x1  = '0;
      head.y1  = '0;
      head.x2  = WIDTH_BITS'(SCREEN_W - 1);
      head.y2  = HEIGHT_BITS'(SCREEN_H - 1);
      head.rad = '0;
    end
  end

  // Done of the engine that the latched opcode selected. All other dones are ignored.
  always_comb begin
    sel_done = 1'b0;
    case (instr_reg.opcode)
      OP_LINE:           sel_done = line_done_i;
      OP_CIRCLE:         sel_done = circle_done_i;
      OP_RECT, OP_CLEAR: sel_done = fill_done_i;
      default:           sel_done = 1'b0;
    endcase
  end

`ifdef GPU_DISPATCH_TIMEOUT_EN
  gpu_dispatch_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .n_rst  (n_rst),
    .load   (state_reg == DECODE),
    .enable (state_reg == WAIT),
    .expire (timer_expire)
  );
`else
  assign timer_expire = 1'b0;
`endif

  // Next-state and strobe decode. Starts and illegal_op are combinational in DECODE.
  always_comb begin
    state_next     = state_reg;
    pop            = 1'b0;
    line_start_o   = 1'b0;
    circle_start_o = 1'b0;
    fill_start_o   = 1'b0;
    illegal_op_o   = 1'b0;
    count_inc      = 1'b0;
    timeout_set    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty_i) begin
          pop        = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        case (instr_reg.opcode)
          OP_NOP: state_next = IDLE;
          OP_LINE: begin
            line_start_o = 1'b1;
            count_inc    = 1'b1;
            state_next   = WAIT;
          end
          OP_CIRCLE: begin
            circle_start_o = 1'b1;
            count_inc      = 1'b1;
            state_next     = WAIT;
          end
          OP_RECT, OP_CLEAR: begin
            fill_start_o = 1'b1;
            count_inc    = 1'b1;
            state_next   = WAIT;
          end
          default: begin
            illegal_op_o = 1'b1;
            state_next   = IDLE;
          end
        endcase
      end
      WAIT: begin
        // A done that arrives on the expiry cycle wins; no timeout is flagged.
        if (sel_done) begin
          state_next = IDLE;
        end else if (timer_expire) begin
          timeout_set = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Operand latch. It loads only on a pop, so the operands hold until the next pop.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)   instr_reg <= '0;
    else if (pop) instr_reg <= head;
  end

  // Issued-instruction counter. It wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)         count_reg <= '0;
    else if (count_inc) count_reg <= count_reg + 16'd1;
  end

  // Sticky timeout flag. It clears only on reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)           timeout_reg <= 1'b0;
    else if (timeout_set) timeout_reg <= 1'b1;
  end

  // The pop strobe is gated with reset, so the FIFO never sees a pop during reset.
  assign pop_instruction_o = pop & n_rst;
  assign busy_o            = (state_reg != IDLE);
  assign timeout_o         = timeout_reg;
  assign instr_count_o     = count_reg;
  assign x1_o              = instr_reg.x1;
  assign x2_o              = instr_reg.x2;
  assign rad_o             = instr_reg.rad;
  assign y1_o              = instr_reg.y1;
  assign y2_o              = instr_reg.y2;
  assign r_o               = instr_reg.r;
  assign g_o               = instr_reg.g;
  assign b_o               = instr_reg.b;
  assign oct_o             = instr_reg.oct;

endmodule
